alu_control_sequencer: RTL and testbench

- Multicycle control sequencer for the 8-bit CPU. It is the driving end of the ALU interface.
- Accepts one 32-bit instruction via a valid/ready handshake and decodes it.
- Drives the ALU operation code, operand-mux selects and register-file addresses, then waits a fixed settle time for the ALU's delayed outputs.
- Issues the register write-back strobe, or a branch/jump pulse based on the ALU's ZERO flag.

---
 rtl/alu_control_sequencer_if.sv | 32 +++
 rtl/alu_control_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// Bus between the multicycle control sequencer (master) and the instruction
// source / ALU / register file it drives (slave).
interface alu_control_sequencer_if;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        ZERO;
    logic [2:0]  ALUOP;
    logic        IMM_SEL;
    logic        NEG_SEL;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic [7:0]  IMMEDIATE;
    logic        WRITE_ENABLE;
    logic        JUMP;
    logic        BRANCH_TAKEN;
    logic [7:0]  OFFSET;
    logic        ILLEGAL;

    modport master (
        input  INSTRUCTION, INSTR_VALID, ZERO,
        output INSTR_READY, ALUOP, IMM_SEL, NEG_SEL, READREG1, READREG2,
               WRITEREG, IMMEDIATE, WRITE_ENABLE, JUMP, BRANCH_TAKEN, OFFSET, ILLEGAL
    );

    modport slave (
        output INSTRUCTION, INSTR_VALID, ZERO,
        input  INSTR_READY, ALUOP, IMM_SEL, NEG_SEL, READREG1, READREG2,
               WRITEREG, IMMEDIATE, WRITE_ENABLE, JUMP, BRANCH_TAKEN, OFFSET, ILLEGAL
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Multicycle sequencer: accepts one instruction, drives ALU controls for a fixed
// settle time, then issues a write-back, jump or branch strobe.
module alu_control_sequencer #(
    parameter int ALU_SETTLE = 2,
    parameter int CNT_W      = 4
) (
    input  logic CLK,
    input  logic RESET,
    alu_control_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero_q;
    logic             r_is_write;
    logic             r_is_jump;
    logic             r_is_beq;
    logic             r_is_illegal;
    logic [2:0]       r_aluop;
    logic             r_imm_sel;
    logic             r_neg_sel;
    logic [2:0]       r_readreg1;
    logic [2:0]       r_readreg2;
    logic [2:0]       r_writereg;
    logic [7:0]       r_immediate;
    logic [7:0]       r_offset;

    logic [2:0]       w_dec_aluop;
    logic             w_dec_imm_sel;
    logic             w_dec_neg_sel;
    logic             w_dec_write;
    logic             w_dec_jump;
    logic             w_dec_beq;
    logic             w_dec_illegal;
    logic             w_accept;
    logic             w_settled;
    logic             w_ready;
    logic             w_we;
    logic             w_jump;
    logic             w_br;
    logic             w_ill;
    logic             w_unused;

    assign w_unused  = ^bus.INSTRUCTION[15:11];
    assign w_accept  = (r_state == S_IDLE) && bus.INSTR_VALID;
    assign w_settled = (r_cnt == CNT_W'(ALU_SETTLE - 1));

    always_comb begin
        w_dec_aluop   = 3'b000;
        w_dec_imm_sel = 1'b0;
        w_dec_neg_sel = 1'b0;
        w_dec_write   = 1'b0;
        w_dec_jump    = 1'b0;
        w_dec_beq     = 1'b0;
        w_dec_illegal = 1'b0;
        case (bus.INSTRUCTION[31:24])
            8'h00: begin w_dec_imm_sel = 1'b1; w_dec_write = 1'b1; end
            8'h01: w_dec_write = 1'b1;
            8'h02: begin w_dec_aluop = 3'b001; w_dec_write = 1'b1; end
            8'h03: begin w_dec_aluop = 3'b001; w_dec_neg_sel = 1'b1; w_dec_write = 1'b1; end
            8'h04: begin w_dec_aluop = 3'b010; w_dec_write = 1'b1; end
            8'h05: begin w_dec_aluop = 3'b011; w_dec_write = 1'b1; end
            8'h06: w_dec_jump = 1'b1;
            8'h07: begin w_dec_aluop = 3'b001; w_dec_neg_sel = 1'b1; w_dec_beq = 1'b1; end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Decoded fields are captured at the accept edge and held until the next accept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_is_write   <= 1'b0;
            r_is_jump    <= 1'b0;
            r_is_beq     <= 1'b0;
            r_is_illegal <= 1'b0;
            r_aluop      <= 3'b000;
            r_imm_sel    <= 1'b0;
            r_neg_sel    <= 1'b0;
            r_readreg1   <= 3'b000;
            r_readreg2   <= 3'b000;
            r_writereg   <= 3'b000;
            r_immediate  <= 8'h00;
            r_offset     <= 8'h00;
        end else if (w_accept) begin
            r_is_write   <= w_dec_write;
            r_is_jump    <= w_dec_jump;
            r_is_beq     <= w_dec_beq;
            r_is_illegal <= w_dec_illegal;
            r_aluop      <= w_dec_aluop;
            r_imm_sel    <= w_dec_imm_sel;
            r_neg_sel    <= w_dec_neg_sel;
            r_readreg1   <= bus.INSTRUCTION[10:8];
            r_readreg2   <= bus.INSTRUCTION[2:0];
            r_writereg   <= bus.INSTRUCTION[18:16];
            r_immediate  <= bus.INSTRUCTION[7:0];
            r_offset     <= bus.INSTRUCTION[23:16];
        end
    end

    // ZERO is only trusted on the edge that leaves EXEC, after the ALU has settled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_zero_q <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_settled) begin
                r_zero_q <= bus.ZERO;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_jump  = 1'b0;
        w_br    = 1'b0;
        w_ill   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.INSTR_VALID) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_ill = r_is_illegal;
                if (r_is_illegal)   w_next = S_IDLE;
                else if (r_is_jump) w_next = S_WB;
                else                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_settled) w_next = S_WB;
            end
            S_WB: begin
                w_we   = r_is_write;
                w_jump = r_is_jump;
                w_br   = r_is_beq & r_zero_q;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.INSTR_READY  = w_ready & ~RESET;
    assign bus.WRITE_ENABLE = w_we;
    assign bus.JUMP         = w_jump;
    assign bus.BRANCH_TAKEN = w_br;
    assign bus.ILLEGAL      = w_ill;
    assign bus.ALUOP        = r_aluop;
    assign bus.IMM_SEL      = r_imm_sel;
    assign bus.NEG_SEL      = r_neg_sel;
    assign bus.READREG1     = r_readreg1;
    assign bus.READREG2     = r_readreg2;
    assign bus.WRITEREG     = r_writereg;
    assign bus.IMMEDIATE    = r_immediate;
    assign bus.OFFSET       = r_offset;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: expected strobes are queued at issue
// time and matched by a monitor on the falling clock edge.
module tb_alu_control_sequencer;

    localparam int SETTLE = 2;
    localparam int K_NONE = 0;
    localparam int K_WE   = 1;
    localparam int K_JUMP = 2;
    localparam int K_BR   = 3;
    localparam int K_ILL  = 4;
    localparam logic [31:0] GARBAGE = 32'h0207_0505;

    typedef struct {
        logic [31:0] instr;
        logic        zexit;
        int          kind;
        logic [2:0]  aluop;
        logic        imm_sel;
        logic        neg_sel;
        logic [2:0]  wr;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic [7:0]  imm;
        logic [7:0]  off;
        int          rdy;
    } vec_t;

    typedef struct {
        int   kind;
        int   cyc;
        vec_t v;
    } exp_t;

    logic CLK;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vt[$];

    alu_control_sequencer_if bus();

    alu_control_sequencer #(.ALU_SETTLE(SETTLE), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic zexit, input int kind,
                                input logic [2:0] aluop, input logic imm_sel, input logic neg_sel,
                                input logic [2:0] wr, input logic [2:0] rr1, input logic [2:0] rr2,
                                input logic [7:0] imm, input logic [7:0] off, input int rdy);
        vec_t v;
        v.instr = instr; v.zexit = zexit; v.kind = kind; v.aluop = aluop;
        v.imm_sel = imm_sel; v.neg_sel = neg_sel; v.wr = wr; v.rr1 = rr1; v.rr2 = rr2;
        v.imm = imm; v.off = off; v.rdy = rdy;
        return v;
    endfunction

    // Monitor: any strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        int   n;
        int   act;
        exp_t e;
        n = int'(bus.WRITE_ENABLE) + int'(bus.JUMP) + int'(bus.BRANCH_TAKEN) + int'(bus.ILLEGAL);
        if (n > 1) check("strobe_exclusive", n, 1);
        if (n != 0) begin
            act = bus.WRITE_ENABLE ? K_WE : bus.JUMP ? K_JUMP : bus.BRANCH_TAKEN ? K_BR : K_ILL;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", act, K_NONE);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", act, e.kind);
                check("strobe_cycle", cyc, e.cyc);
                case (e.kind)
                    K_WE: begin
                        check("we_aluop", bus.ALUOP, e.v.aluop);
                        check("we_imm_sel", bus.IMM_SEL, e.v.imm_sel);
                        check("we_neg_sel", bus.NEG_SEL, e.v.neg_sel);
                        check("we_writereg", bus.WRITEREG, e.v.wr);
                        check("we_readreg1", bus.READREG1, e.v.rr1);
                        check("we_readreg2", bus.READREG2, e.v.rr2);
                        check("we_immediate", bus.IMMEDIATE, e.v.imm);
                    end
                    K_BR: begin
                        check("br_aluop", bus.ALUOP, e.v.aluop);
                        check("br_neg_sel", bus.NEG_SEL, e.v.neg_sel);
                        check("br_offset", bus.OFFSET, e.v.off);
                    end
                    K_JUMP: check("jump_offset", bus.OFFSET, e.v.off);
                    default: ;
                endcase
            end
        end
    end

    task automatic check_outputs_clear(input string tag);
        check({tag, "_ready"}, bus.INSTR_READY, 0);
        check({tag, "_fields"}, {bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL, bus.READREG1,
                                 bus.READREG2, bus.WRITEREG, bus.IMMEDIATE}, 0);
        check({tag, "_strobes"}, {bus.OFFSET, bus.WRITE_ENABLE, bus.JUMP,
                                  bus.BRANCH_TAKEN, bus.ILLEGAL}, 0);
    endtask

    // Called at a falling edge; returns at the falling edge where INSTR_READY is back.
    task automatic run_vec(input vec_t v);
        int   w;
        int   wb;
        exp_t e;
        bus.INSTRUCTION = v.instr;
        bus.INSTR_VALID = 1'b1;
        w = 0;
        while (!bus.INSTR_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (!bus.INSTR_READY) begin
            check("accept_timeout", 0, 1);
            return;
        end
        if (v.kind != K_NONE) begin
            case (v.kind)
                K_WE, K_BR: wb = SETTLE + 2;
                K_JUMP:     wb = 2;
                default:    wb = 1;
            endcase
            e.kind = v.kind;
            e.cyc  = cyc + wb;
            e.v    = v;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.INSTRUCTION = GARBAGE;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            bus.ZERO = (k == SETTLE + 1) ? v.zexit : ~v.zexit;
            if (k == 1 && v.kind == K_WE)
                check("decode_fields", {bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL, bus.WRITEREG},
                      {v.aluop, v.imm_sel, v.neg_sel, v.wr});
            if (bus.INSTR_READY) begin
                check("ready_cycle", k, v.rdy);
                return;
            end
        end
        check("ready_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt.push_back(mk(32'h0005_002A, 1'b0, K_WE,   3'b000, 1'b1, 1'b0, 3'd5, 3'd0, 3'd2, 8'h2A, 8'h05, SETTLE + 3));
        vt.push_back(mk(32'h0102_0700, 1'b0, K_WE,   3'b000, 1'b0, 1'b0, 3'd2, 3'd7, 3'd0, 8'h00, 8'h02, SETTLE + 3));
        vt.push_back(mk(32'h0204_0102, 1'b0, K_WE,   3'b001, 1'b0, 1'b0, 3'd4, 3'd1, 3'd2, 8'h02, 8'h04, SETTLE + 3));
        vt.push_back(mk(32'h0303_0102, 1'b0, K_WE,   3'b001, 1'b0, 1'b1, 3'd3, 3'd1, 3'd2, 8'h02, 8'h03, SETTLE + 3));
        vt.push_back(mk(32'h0406_0503, 1'b0, K_WE,   3'b010, 1'b0, 1'b0, 3'd6, 3'd5, 3'd3, 8'h03, 8'h06, SETTLE + 3));
        vt.push_back(mk(32'h0507_0604, 1'b0, K_WE,   3'b011, 1'b0, 1'b0, 3'd7, 3'd6, 3'd4, 8'h04, 8'h07, SETTLE + 3));
        vt.push_back(mk(32'h07FC_0102, 1'b1, K_BR,   3'b001, 1'b0, 1'b1, 3'd4, 3'd1, 3'd2, 8'h02, 8'hFC, SETTLE + 3));
        vt.push_back(mk(32'h07FC_0102, 1'b0, K_NONE, 3'b001, 1'b0, 1'b1, 3'd4, 3'd1, 3'd2, 8'h02, 8'hFC, SETTLE + 3));
        vt.push_back(mk(32'h0610_0000, 1'b0, K_JUMP, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h10, 3));
        vt.push_back(mk(32'h9A00_0000, 1'b0, K_ILL,  3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 2));
        vt.push_back(mk(32'h0811_0102, 1'b0, K_ILL,  3'b000, 1'b0, 1'b0, 3'd1, 3'd1, 3'd2, 8'h02, 8'h11, 2));
        vt.push_back(mk(32'hFF00_0000, 1'b0, K_ILL,  3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 2));
        vt.push_back(mk(32'h00FF_0081, 1'b0, K_WE,   3'b000, 1'b1, 1'b0, 3'd7, 3'd0, 3'd1, 8'h81, 8'hFF, SETTLE + 3));

        RESET           = 1'b1;
        bus.INSTR_VALID = 1'b1;
        bus.INSTRUCTION = vt[0].instr;
        bus.ZERO        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_outputs_clear("in_reset");
        end
        RESET = 1'b0;
        #1;
        check("ready_after_reset", bus.INSTR_READY, 1);

        foreach (vt[i]) run_vec(vt[i]);
        bus.INSTR_VALID = 1'b0;

        // Reset landing in the EXEC phase of an add must discard it silently.
        @(negedge CLK);
        bus.INSTRUCTION = 32'h0201_0203;
        bus.INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.INSTR_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_outputs_clear("exec_reset");
        RESET = 1'b0;
        #1;
        check("ready_after_exec_reset", bus.INSTR_READY, 1);
        repeat (SETTLE + 6) @(negedge CLK);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
